// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_pkg;

  localparam int          IFU_ADDR_W   = 32;
  localparam int          IFU_DATA_W   = 32;
  localparam logic [31:0] IFU_RESET_PC = 32'h8000_0000;
  localparam int          FETCH_STEP   = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [IFU_ADDR_W-1:0] pc;
    logic [IFU_DATA_W-1:0] inst;
  } ibuf_entry_t;

endpackage

// File: rtl/ifu_pc_queue.sv
// In-order FIFO of issued fetch addresses; the head is the pc of the next response.
module ifu_pc_queue #(
  parameter int DEPTH = 4,
  parameter int W     = 32
)(
  input  logic                     i_clk,
  input  logic                     i_rstn,
  input  logic                     i_push,
  input  logic [W-1:0]             i_wdata,
  input  logic                     i_pop,
  output logic [W-1:0]             o_rdata,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_C = CNT_W'(DEPTH);

  logic [DEPTH-1:0][W-1:0] mem;
  logic [PTR_W-1:0]        wptr, rptr;
  logic                    do_push, do_pop;

  assign do_push = i_push & (o_count != FULL_C);
  assign do_pop  = i_pop  & (o_count != '0);
  assign o_rdata = mem[rptr];

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      wptr    <= '0;
      rptr    <= '0;
      o_count <= '0;
    end else begin
      if (do_push) wptr <= wptr + PTR_W'(1);
      if (do_pop)  rptr <= rptr + PTR_W'(1);
      o_count <= o_count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Storage needs no reset: only entries below o_count are ever read.
  always_ff @(posedge i_clk) begin
    if (do_push) mem[wptr] <= i_wdata;
  end

endmodule

// File: rtl/ifu_fetch_ctrl.sv
// Fetch sequencer: issues sequential fetches under outstanding/buffer credit limits,
// pairs in-order responses with their pc and drops responses made stale by a redirect.
module ifu_fetch_ctrl
  import ifu_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 32,
  parameter int                MAX_OUTST = 4,
  parameter int                IBUF_DPTH = 8,
  parameter logic [ADDR_W-1:0] RESET_PC  = ADDR_W'(IFU_RESET_PC)
)(
  input  logic                       i_clk,
  input  logic                       i_rstn,
  input  logic                       i_halt,
  input  logic                       i_redirect,
  input  logic [ADDR_W-1:0]          i_redirect_pc,
  output logic                       o_req_valid,
  output logic [ADDR_W-1:0]          o_req_addr,
  input  logic                       i_req_ready,
  input  logic                       i_rsp_valid,
  input  logic [DATA_W-1:0]          i_rsp_data,
  input  logic [$clog2(IBUF_DPTH):0] i_ibuf_cnt,
  output logic                       o_ibuf_flush,
  output logic                       o_ibuf_wen,
  output logic [ADDR_W+DATA_W-1:0]   o_ibuf_data,
  output logic                       o_busy
);

  localparam int CNT_W = $clog2(MAX_OUTST) + 1;
  localparam int IC_W  = $clog2(IBUF_DPTH) + 1;
  localparam int SUM_W = ((CNT_W > IC_W) ? CNT_W : IC_W) + 1;
  localparam logic [CNT_W-1:0] MAX_C  = CNT_W'(MAX_OUTST);
  localparam logic [SUM_W-1:0] DPTH_C = SUM_W'(IBUF_DPTH);

  fetch_state_e      state;
  logic [ADDR_W-1:0] pc, q_head;
  logic [CNT_W-1:0]  outst, stale, live;
  logic [SUM_W-1:0]  credit_sum;
  logic              hs;

  // The queue occupancy is exactly the outstanding-request count.
  ifu_pc_queue #(
    .DEPTH (MAX_OUTST),
    .W     (ADDR_W)
  ) u_pc_queue (
    .i_clk   (i_clk),
    .i_rstn  (i_rstn),
    .i_push  (hs),
    .i_wdata (pc),
    .i_pop   (i_rsp_valid),
    .o_rdata (q_head),
    .o_count (outst)
  );

  assign live        = outst - stale;
  assign credit_sum  = SUM_W'(live) + SUM_W'(i_ibuf_cnt);
  assign o_req_valid = (state == RUN) & ~i_redirect & (outst < MAX_C) & (credit_sum < DPTH_C);
  assign o_req_addr  = pc;
  assign hs          = o_req_valid & i_req_ready;

  assign o_ibuf_flush = i_redirect;
  assign o_ibuf_wen   = i_rsp_valid & (stale == '0) & ~i_redirect;
  assign o_ibuf_data  = {q_head, i_rsp_data};
  assign o_busy       = (outst != '0);

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state <= IDLE;
      pc    <= RESET_PC;
      stale <= '0;
    end else begin
      case (state)
        IDLE:    state <= RUN;
        RUN:     if (i_halt)  state <= HOLD;
        HOLD:    if (!i_halt) state <= RUN;
        default: state <= IDLE;
      endcase

      if (i_redirect)  pc <= i_redirect_pc;
      else if (hs)     pc <= pc + ADDR_W'(FETCH_STEP);

      // A response arriving with the redirect is already discarded, so it is not counted stale.
      if (i_redirect)
        stale <= outst - CNT_W'(i_rsp_valid);
      else if (i_rsp_valid && (stale != '0))
        stale <= stale - CNT_W'(1);
    end
  end

  a_rsp_has_pc: assert property (@(posedge i_clk) disable iff (!i_rstn)
    i_rsp_valid |-> (outst != '0));

endmodule
